// File: rtl/mac_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mac_rr_scheduler
// Purpose  : Round-robin scheduler that shares one MAC/accumulator datapath
//            between NREQ requesters. It accepts one operation per grant and
//            drives the datapath through a start/done handshake. It returns
//            the accumulator value tagged with the id of the granted requester.
// Ports    : clk, rst_n (async, active-low)
//            req_valid/req_clr/req_a/req_b -> req_ready   requester side
//            mac_start/mac_clr/mac_a/mac_b <- mac_done/mac_acc   datapath
//            rsp_valid/rsp_id/rsp_data/rsp_err <- rsp_ready      response
//            state_dbg                                           FSM state
// Options  : `define MAC_SCHED_TIMEOUT_EN enables the WAIT-state watchdog.
//            If the watchdog fires, the block returns rsp_err=1 and
//            rsp_data=0 after TIMEOUT cycles.
// Revision : 1.0  initial release
// ============================================================================
module mac_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_clr,
  input  logic [NREQ*DW-1:0]       req_a,
  input  logic [NREQ*DW-1:0]       req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     mac_start,
  output logic                     mac_clr,
  output logic [DW-1:0]            mac_a,
  output logic [DW-1:0]            mac_b,
  input  logic                     mac_done,
  input  logic [DW-1:0]            mac_acc,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DW-1:0]            rsp_data,
  output logic                     rsp_err,
  output logic [1:0]               state_dbg
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Elaboration-time parameter sanity checks
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("mac_rr_scheduler: NREQ must be in 2..8");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("mac_rr_scheduler: TIMEOUT must be at least 2");
  end

  logic [1:0]     r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic           r_clr;
  logic [DW-1:0]  r_a;
  logic [DW-1:0]  r_b;
  logic [DW-1:0]  r_data;

  logic           w_found;
  logic [IDW-1:0] w_gnt_id;
  logic           w_timeout;

  // (base + off) mod NREQ. NREQ need not be a power of two, so the wrap is
  // explicit rather than a natural overflow of the IDW-bit field.
  function automatic logic [IDW-1:0] f_wrap(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return sum[IDW-1:0];
  endfunction

  // Find the first valid requester, starting at the rotating pointer.
  always_comb begin : p_grant
    logic [IDW-1:0] v_idx;
    w_found  = 1'b0;
    w_gnt_id = '0;
    v_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = f_wrap(r_ptr, k);
      if (!w_found && req_valid[v_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = v_idx;
      end
    end
  end

  // The accept strobe is gated by rst_n so that it stays low while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (r_state == S_IDLE) && w_found) req_ready[w_gnt_id] = 1'b1;
  end

`ifdef MAC_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign w_timeout = (r_state == S_WAIT) && (r_cnt == CNT_W'(TIMEOUT - 1));

  // The counter is cleared in ISSUE, so every WAIT visit starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (mac_done)       r_err <= 1'b0;
        else if (w_timeout) r_err <= 1'b1;
      end
    end
  end

  assign rsp_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_clr   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_id    <= w_gnt_id;
            r_clr   <= req_clr[w_gnt_id];
            r_a     <= req_a[w_gnt_id*DW +: DW];
            r_b     <= req_b[w_gnt_id*DW +: DW];
            r_state <= S_ISSUE;
          end
        end
        // A mac_done seen here belongs to no operation of ours and is dropped.
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (mac_done) begin
            r_data  <= mac_acc;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            r_data  <= '0;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_ptr   <= f_wrap(r_id, 1);
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mac_start = (r_state == S_ISSUE);
  assign mac_clr   = r_clr;
  assign mac_a     = r_a;
  assign mac_b     = r_b;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mac_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_rr_scheduler
// Purpose  : Directed self-checking bench for mac_rr_scheduler. It uses an
//            NREQ=4 instance for the main checks and an NREQ=3 instance for
//            the pointer wrap-around check.
// Revision : 1.0  initial release
// ============================================================================
module tb_mac_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [3:0]  req_valid, req_clr, req_ready;
  logic [31:0] req_a, req_b;
  logic        mac_start, mac_clr, mac_done, rsp_valid, rsp_ready, rsp_err;
  logic [7:0]  mac_a, mac_b, mac_acc, rsp_data;
  logic [1:0]  rsp_id, state_dbg;

  logic [2:0]  d3_req_valid, d3_req_clr, d3_req_ready;
  logic [23:0] d3_req_a, d3_req_b;
  logic        d3_mac_start, d3_mac_clr, d3_mac_done, d3_rsp_valid, d3_rsp_ready, d3_rsp_err;
  logic [7:0]  d3_mac_a, d3_mac_b, d3_mac_acc, d3_rsp_data;
  logic [1:0]  d3_rsp_id, d3_state_dbg;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mac_rr_scheduler #(.NREQ(4), .DW(8), .TIMEOUT(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_clr(req_clr), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .mac_start(mac_start), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
    .mac_done(mac_done), .mac_acc(mac_acc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .state_dbg(state_dbg)
  );

  mac_rr_scheduler #(.NREQ(3), .DW(8), .TIMEOUT(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(d3_req_valid), .req_clr(d3_req_clr), .req_a(d3_req_a), .req_b(d3_req_b),
    .req_ready(d3_req_ready),
    .mac_start(d3_mac_start), .mac_clr(d3_mac_clr), .mac_a(d3_mac_a), .mac_b(d3_mac_b),
    .mac_done(d3_mac_done), .mac_acc(d3_mac_acc),
    .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_id(d3_rsp_id),
    .rsp_data(d3_rsp_data), .rsp_err(d3_rsp_err), .state_dbg(d3_state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Finish whatever the 4-requester DUT has in flight and return it to IDLE.
  task automatic run_to_idle(input string tag);
    int cyc;
    cyc = 0;
    while (state_dbg != 2'd0) begin
      if (cyc == 30) begin
        chk(tag, 32'd1, 32'd0);
        break;
      end
      req_valid = 4'h0;
      rsp_ready = 1'b1;
      mac_done  = (state_dbg == 2'd2);
      tick();
      cyc++;
    end
    mac_done  = 1'b0;
    rsp_ready = 1'b0;
  endtask

  int exp_g [5];
  int exp_g3[3];
  int ng, nr, cyc;

  initial begin
    exp_g  = '{0, 1, 2, 3, 0};
    exp_g3 = '{1, 2, 0};
    rst_n = 1'b0;
    req_valid = 4'hF; req_clr = '0; req_a = '0; req_b = '0;
    mac_done = 1'b0; mac_acc = '0; rsp_ready = 1'b0;
    d3_req_valid = '0; d3_req_clr = '0; d3_req_a = '0; d3_req_b = '0;
    d3_mac_done = 1'b0; d3_mac_acc = '0; d3_rsp_ready = 1'b0;

    // ---- reset state ----
    #3;
    chk("rst_state", state_dbg, 2'd0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_mac_start", mac_start, 1'b0);
    chk("rst_req_ready", req_ready, 4'h0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    req_valid = 4'h0;

    // ---- single request, latency and ignored early mac_done ----
    tick();                                   // cycle T
    req_valid = 4'b0001; req_clr = 4'b0001;
    req_a[7:0] = 8'h12; req_b[7:0] = 8'h03;
    #1;
    chk("t2_ready", req_ready, 4'b0001);
    tick();                                   // T+1
    req_valid = 4'h0; req_clr = 4'h0;
    mac_done = 1'b1; mac_acc = 8'hEE;         // ISSUE: must be ignored
    #1;
    chk("t2_start", mac_start, 1'b1);
    chk("t2_mac_a", mac_a, 8'h12);
    chk("t2_mac_b", mac_b, 8'h03);
    chk("t2_mac_clr", mac_clr, 1'b1);
    tick();                                   // T+2
    mac_done = 1'b0;
    #1;
    chk("t2_start_low", mac_start, 1'b0);
    chk("t2_wait", state_dbg, 2'd2);
    chk("t2_hold_a", mac_a, 8'h12);
    tick();                                   // T+3
    mac_done = 1'b1; mac_acc = 8'h36;
    #1;
    chk("t2_no_rsp_yet", rsp_valid, 1'b0);
    tick();                                   // T+4
    mac_done = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("t2_rsp_valid", rsp_valid, 1'b1);
    chk("t2_rsp_id", rsp_id, 2'd0);
    chk("t2_rsp_data", rsp_data, 8'h36);
    chk("t2_rsp_err", rsp_err, 1'b0);
    tick();                                   // T+5
    rsp_ready = 1'b0;
    #1;
    chk("t2_rsp_drop", rsp_valid, 1'b0);
    chk("t2_idle", state_dbg, 2'd0);

    // ---- reset mid-WAIT, late mac_done ignored ----
    req_valid = 4'b1000;
    #1;
    chk("t1_ready", req_ready, 4'b1000);     // pointer now 1, only requester 3 valid
    tick();
    req_valid = 4'h0;
    tick();
    #1;
    chk("t1_in_wait", state_dbg, 2'd2);
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    chk("t1_state", state_dbg, 2'd0);
    chk("t1_rsp_valid", rsp_valid, 1'b0);
    chk("t1_mac_start", mac_start, 1'b0);
    chk("t1_ready_in_rst", req_ready, 4'h0);
    tick();
    rst_n = 1'b1; req_valid = 4'h0;
    mac_done = 1'b1; mac_acc = 8'h77;
    tick();
    mac_done = 1'b0;
    #1;
    chk("t1_late_done_rsp", rsp_valid, 1'b0);
    chk("t1_late_done_state", state_dbg, 2'd0);
    tick();
    #1;
    chk("t1_still_idle", rsp_valid, 1'b0);

    // ---- round robin, all four valid ----
    ng = 0; nr = 0; cyc = 0;
    rsp_ready = 1'b1;
    while (!(ng == 5 && state_dbg == 2'd0)) begin
      if (cyc == 80) begin
        chk("t3_bound", 32'd1, 32'd0);
        break;
      end
      req_valid = (ng < 5) ? 4'hF : 4'h0;
      mac_done  = (state_dbg == 2'd2);
      mac_acc   = 8'h40 + 8'(ng);
      #1;
      if (req_ready != 4'h0) begin
        chk("t3_onehot", 32'($onehot(req_ready)), 32'd1);
        chk("t3_grant", req_ready, 32'd1 << exp_g[ng]);
        ng++;
      end
      if (rsp_valid && nr < 5) begin
        chk("t3_rsp_id", rsp_id, exp_g[nr]);
        nr++;
      end
      tick();
      cyc++;
    end
    chk("t3_nrsp", nr, 5);
    req_valid = 4'h0; mac_done = 1'b0; rsp_ready = 1'b0;

    // ---- backpressure in RESP (pointer now 1) ----
    req_valid = 4'b0100; req_a[23:16] = 8'h55; req_b[23:16] = 8'h02;
    #1;
    chk("t4_ready", req_ready, 4'b0100);
    tick();                                   // ISSUE
    req_valid = 4'h0;
    tick();                                   // WAIT
    mac_done = 1'b1; mac_acc = 8'hAA;
    tick();                                   // RESP, first stalled cycle
    mac_done = 1'b0; req_valid = 4'hF;
    #1;
    chk("t4_rsp_valid", rsp_valid, 1'b1);
    chk("t4_rsp_data", rsp_data, 8'hAA);
    chk("t4_rsp_id", rsp_id, 2'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk("t4_hold_valid", rsp_valid, 1'b1);
      chk("t4_hold_data", rsp_data, 8'hAA);
      chk("t4_hold_id", rsp_id, 2'd2);
      chk("t4_no_ready", req_ready, 4'h0);
    end
    tick();
    rsp_ready = 1'b1;
    #1;
    chk("t4_hs_valid", rsp_valid, 1'b1);
    chk("t4_hs_no_ready", req_ready, 4'h0);
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("t4_rsp_drop", rsp_valid, 1'b0);
    chk("t4_resume", req_ready, 4'b1000);
    tick();
    run_to_idle("t4_drain_bound");

    // ---- NREQ=3 pointer wrap ----
    ng = 0; cyc = 0;
    d3_rsp_ready = 1'b1;
    while (!(ng == 3 && d3_state_dbg == 2'd0)) begin
      if (cyc == 60) begin
        chk("t5_bound", 32'd1, 32'd0);
        break;
      end
      d3_req_valid = (ng == 0) ? 3'b010 : ((ng < 3) ? 3'b101 : 3'b000);
      d3_mac_done  = (d3_state_dbg == 2'd2);
      #1;
      if (d3_req_ready != 3'b000) begin
        chk("t5_grant", d3_req_ready, 32'd1 << exp_g3[ng]);
        ng++;
      end
      tick();
      cyc++;
    end
    chk("t5_ngrants", ng, 3);
    d3_req_valid = '0; d3_mac_done = 1'b0; d3_rsp_ready = 1'b0;

    // ---- no mac_done: watchdog or endless WAIT (pointer now 0) ----
    req_valid = 4'b0001;
    #1;
    chk("t6_ready", req_ready, 4'b0001);
    tick();                                   // ISSUE
    req_valid = 4'h0; mac_acc = 8'h5A; mac_done = 1'b0;
    tick();                                   // first WAIT cycle (count 0)
    #1;
    chk("t6_wait_entry", state_dbg, 2'd2);
    for (int i = 0; i < 15; i++) tick();
    #1;
    chk("t6_before_limit", rsp_valid, 1'b0);
    chk("t6_before_state", state_dbg, 2'd2);
    tick();                                   // 16 cycles after WAIT entry
    #1;
`ifdef MAC_SCHED_TIMEOUT_EN
    chk("t6_to_valid", rsp_valid, 1'b1);
    chk("t6_to_err", rsp_err, 1'b1);
    chk("t6_to_data", rsp_data, 8'h00);
`else
    chk("t6_stay_wait", state_dbg, 2'd2);
    chk("t6_no_rsp", rsp_valid, 1'b0);
    chk("t6_err_zero", rsp_err, 1'b0);
`endif
    run_to_idle("t6_drain_bound");
    chk("t6_idle", state_dbg, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
